// File: rtl/pc_sequencer.sv
// Fetch-stage program counter with prioritised next-address selection
// (stall > ret > call > branch > sequential) and a circular return-address stack.
module pc_sequencer #(
  parameter int unsigned     ADDR_WIDTH   = 32,
  parameter longint unsigned RESET_VECTOR = 0,
  parameter int unsigned     INC          = 4,
  parameter int unsigned     RAS_DEPTH    = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             stall,
  input  logic                             branchTaken,
  input  logic [ADDR_WIDTH-1:0]            branchTarget,
  input  logic                             call,
  input  logic [ADDR_WIDTH-1:0]            callTarget,
  input  logic                             ret,
  output logic [ADDR_WIDTH-1:0]            addressOut,
  output logic [$clog2(RAS_DEPTH+1)-1:0]   rasCount,
  output logic                             rasEmpty,
  output logic                             rasFull,
  output logic                             rasOverflow,
  output logic                             rasUnderflow
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);

  localparam logic [ADDR_WIDTH-1:0] RV_W     = ADDR_WIDTH'(RESET_VECTOR);
  localparam logic [ADDR_WIDTH-1:0] INC_W    = ADDR_WIDTH'(INC);
  localparam logic [PTR_W-1:0]      PTR_LAST = PTR_W'(RAS_DEPTH - 1);
  localparam logic [CNT_W-1:0]      CNT_FULL = CNT_W'(RAS_DEPTH);
  localparam logic [CNT_W-1:0]      CNT_ONE  = CNT_W'(1);

  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [PTR_W-1:0]      ptr_q, ptr_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ovf_q, ovf_d;
  logic                  unf_q, unf_d;

  logic [ADDR_WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [ADDR_WIDTH-1:0] pc_inc;
  logic [PTR_W-1:0]      ptr_next;
  logic [PTR_W-1:0]      ptr_prev;
  logic                  push_en;

  // ptr_q names the slot the next push writes; the top entry sits one below it.
  assign pc_inc   = pc_q + INC_W;
  assign ptr_next = (ptr_q == PTR_LAST) ? '0 : ptr_q + PTR_W'(1);
  assign ptr_prev = (ptr_q == '0) ? PTR_LAST : ptr_q - PTR_W'(1);

  always_comb begin
    pc_d    = pc_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    push_en = 1'b0;
    if (!stall) begin
      if (ret) begin
        if (cnt_q != '0) begin
          pc_d  = ras_mem[ptr_prev];
          ptr_d = ptr_prev;
          cnt_d = cnt_q - CNT_ONE;
        end else begin
          pc_d  = pc_inc;
          unf_d = 1'b1;
        end
      end else if (call) begin
        // When full, the write slot already holds the oldest entry, so it is simply overwritten.
        push_en = 1'b1;
        ptr_d   = ptr_next;
        pc_d    = callTarget;
        if (cnt_q == CNT_FULL) begin
          ovf_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end else if (branchTaken) begin
        pc_d = branchTarget;
      end else begin
        pc_d = pc_inc;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q  <= RV_W;
      ptr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      pc_q  <= pc_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  // Stack contents are never cleared; the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_en) begin
      ras_mem[ptr_q] <= pc_inc;
    end
  end

  assign addressOut   = pc_q;
  assign rasCount     = cnt_q;
  assign rasEmpty     = (cnt_q == '0);
  assign rasFull      = (cnt_q == CNT_FULL);
  assign rasOverflow  = ovf_q;
  assign rasUnderflow = unf_q;

endmodule
